// File: rtl/irq_pend_enc8.sv
// rtl/irq_pend_enc8.sv - request capture into a pending register, fixed-priority 8-to-3 encode, valid/ack handshake
module irq_pend_enc8 #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic       valid,
  output logic [2:0] y,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state, state_next;
  logic [7:0] req_d;
  logic [7:0] set;
  logic [7:0] clr;
  logic [7:0] cand;
  logic [2:0] sel;
  logic [2:0] y_next;

  assign set   = EDGE ? (req & ~req_d) : req;
  assign clr   = (state == PRESENT && ack) ? (8'b1 << y) : 8'b0;
  assign cand  = pending & ~mask;
  assign valid = (state == PRESENT);

  // Ascending scan so the highest set bit is the last assignment to win.
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) sel = 3'(i);
    end
  end

  always_comb begin
    state_next = state;
    y_next     = y;
    case (state)
      IDLE: begin
        if (en && (cand != 8'b0)) begin
          y_next     = sel;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A set landing on the bit being cleared keeps it pending and is not an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      y        <= 3'd0;
      req_d    <= 8'b0;
      pending  <= 8'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      y        <= y_next;
      req_d    <= req;
      pending  <= (pending & ~clr) | set;
      overflow <= |(set & pending & ~clr);
    end
  end

endmodule

// File: tb/tb_irq_pend_enc8.sv
// tb/tb_irq_pend_enc8.sv - directed self-checking bench for irq_pend_enc8 (edge and level instances)
module tb_irq_pend_enc8;

  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic [7:0] req, mask;
  logic       valid_e, overflow_e, valid_l, overflow_l;
  logic [2:0] y_e, y_l;
  logic [7:0] pending_e, pending_l;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_pend_enc8 #(.EDGE(1'b1)) dut_edge (
    .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask), .ack(ack),
    .valid(valid_e), .y(y_e), .pending(pending_e), .overflow(overflow_e)
  );

  irq_pend_enc8 #(.EDGE(1'b0)) dut_level (
    .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask), .ack(ack),
    .valid(valid_l), .y(y_l), .pending(pending_l), .overflow(overflow_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ack = 1'b0; req = 8'h00; mask = 8'h00;
    #1;
    // 1. reset then single request
    step(); step();
    check("rst_valid", {7'b0, valid_e}, 8'h00);
    check("rst_pending", pending_e, 8'h00);
    check("rst_y", {5'b0, y_e}, 8'h00);
    check("rst_ovf", {7'b0, overflow_e}, 8'h00);
    rst = 1'b0; req = 8'h04;
    step();
    check("t1_pending", pending_e, 8'h04);
    check("t1_valid_early", {7'b0, valid_e}, 8'h00);
    check("t1_ovf0", {7'b0, overflow_e}, 8'h00);
    step();
    check("t1_valid", {7'b0, valid_e}, 8'h01);
    check("t1_y", {5'b0, y_e}, 8'h02);
    check("t1_ovf1", {7'b0, overflow_e}, 8'h00);
    ack = 1'b1;
    step();
    check("t1_ack_valid", {7'b0, valid_e}, 8'h00);
    check("t1_ack_pending", pending_e, 8'h00);
    check("t1_ovf2", {7'b0, overflow_e}, 8'h00);
    ack = 1'b0; req = 8'h00;
    step();

    // 2. priority and drain
    req = 8'hA1;
    step();
    check("t2_pending", pending_e, 8'hA1);
    req = 8'h00;
    step();
    check("t2_y7", {4'b0, valid_e, y_e}, 8'h0F);
    ack = 1'b1;
    step();
    check("t2_gap1", {7'b0, valid_e}, 8'h00);
    check("t2_pend21", pending_e, 8'h21);
    step();
    check("t2_y5", {4'b0, valid_e, y_e}, 8'h0D);
    step();
    check("t2_gap2", {7'b0, valid_e}, 8'h00);
    check("t2_pend01", pending_e, 8'h01);
    step();
    check("t2_y0", {4'b0, valid_e, y_e}, 8'h08);
    step();
    check("t2_gap3", {7'b0, valid_e}, 8'h00);
    check("t2_pend00", pending_e, 8'h00);
    ack = 1'b0;

    // 3. masking and en gating
    mask = 8'h80; req = 8'h81;
    step();
    check("t3_pending", pending_e, 8'h81);
    req = 8'h00;
    step();
    check("t3_y0", {4'b0, valid_e, y_e}, 8'h08);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t3_retain", pending_e, 8'h80);
    step();
    check("t3_masked_idle", {7'b0, valid_e}, 8'h00);
    en = 1'b0; mask = 8'h00;
    step();
    check("t3_en0_a", {7'b0, valid_e}, 8'h00);
    step();
    check("t3_en0_b", {7'b0, valid_e}, 8'h00);
    en = 1'b1;
    step();
    check("t3_en1_y7", {4'b0, valid_e, y_e}, 8'h0F);
    ack = 1'b1;
    step();
    check("t3_drain", pending_e, 8'h00);
    ack = 1'b0;

    // 4. hold stability under req/mask changes
    req = 8'h40;
    step();
    req = 8'h00;
    step();
    check("t4_y6", {4'b0, valid_e, y_e}, 8'h0E);
    req = 8'h80; mask = 8'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      req = 8'h00;
      check("t4_hold", {4'b0, valid_e, y_e}, 8'h0E);
    end
    check("t4_pend", pending_e, 8'hC0);
    ack = 1'b1;
    step();
    check("t4_after_ack", pending_e, 8'h80);
    ack = 1'b0; mask = 8'h00;
    step();
    check("t4_y7", {4'b0, valid_e, y_e}, 8'h0F);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t4_drain", pending_e, 8'h00);

    // 5. simultaneous set/clear, then overflow
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    check("t5_y3", {4'b0, valid_e, y_e}, 8'h0B);
    req = 8'h08; ack = 1'b1;
    step();
    check("t5_setwins", pending_e, 8'h08);
    check("t5_no_ovf", {7'b0, overflow_e}, 8'h00);
    check("t5_valid0", {7'b0, valid_e}, 8'h00);
    req = 8'h00; ack = 1'b0;
    step();
    check("t5_represent", {4'b0, valid_e, y_e}, 8'h0B);
    req = 8'h08;
    step();
    check("t5_ovf", {7'b0, overflow_e}, 8'h01);
    check("t5_pend", pending_e, 8'h08);
    req = 8'h00;
    step();
    check("t5_ovf_pulse", {7'b0, overflow_e}, 8'h00);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t5_drain", pending_e, 8'h00);

    // 6. level mode and mid-operation reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_pend", pending_l, 8'h00);
    check("t6_rst_valid", {7'b0, valid_l}, 8'h00);
    req = 8'h02; ack = 1'b1;
    step();
    check("t6_pend", pending_l, 8'h02);
    check("t6_idle0", {7'b0, valid_l}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_on", {4'b0, valid_l, y_l}, 8'h09);
      if (i < 2) begin
        step();
        check("t6_off", {7'b0, valid_l}, 8'h00);
        check("t6_pend_kept", pending_l, 8'h02);
      end
    end
    ack = 1'b0; rst = 1'b1;
    step();
    check("t6_mid_rst_valid", {7'b0, valid_l}, 8'h00);
    check("t6_mid_rst_pend", pending_l, 8'h00);
    check("t6_mid_rst_y", {5'b0, y_l}, 8'h00);
    rst = 1'b0; req = 8'h00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_pend_enc8.md
Name: irq_pend_enc8

Overview:
Request-capture and encode stage for the 8-to-3 encoder path. Latches 8 request lines into a pending register and selects the highest-priority unmasked pending bit. Presents that bit's 3-bit index with a valid/ack handshake, and clears the serviced bit on ack. Sits upstream of consumers of a 3-bit source code, such as an interrupt dispatcher or mux select.

Parameters:
EDGE, 1, 1 = capture on rising edge of req bit; 0 = capture while req bit is high (level).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  allows a new index to be presented; does not gate capture
req  input  8  request lines; bit 7 is highest priority
mask  input  8  1 = bit excluded from selection; capture unaffected
ack  input  1  consumer accepts current y; meaningful only while valid=1
valid  output  1  y holds a selected index
y  output  3  encoded index of selected pending bit
pending  output  8  current pending register
overflow  output  1  one-cycle pulse: capture hit a bit already pending

Behaviour:
- Reset: on a rising edge with rst=1, the following reset to 0: pending, req_d (previous req), valid, y, overflow. State goes to IDLE. rst overrides all other inputs.
- Capture:
  - set = EDGE ? (req & ~req_d) : req.
  - req_d <= req every cycle.
  - Because req_d resets to 0, a req bit held high through reset release counts as an edge on the first cycle after reset.
- Clear: clr = one-hot of y, only when valid & ack.
- Pending update: pending <= (pending & ~clr) | set.
  - If set and clr hit the same bit in one cycle, set wins and the bit stays pending.
- overflow <= |(set & pending & ~clr). Registered, high for one cycle.
- Selection: cand = pending & ~mask. sel = index of highest set bit of cand.
- FSM, 2 states:
  - IDLE: valid=0. If en=1 and cand!=0, load y<=sel, valid<=1, go to PRESENT. Otherwise stay; y keeps its last value.
  - PRESENT: valid=1. y, valid and the selection are frozen; changes to mask, en, req or pending do not alter y. If ack=1, valid<=0 and go to IDLE; pending[y] clears in the same edge. If ack=0, hold indefinitely.
- en=0 while in PRESENT does not withdraw valid; the transfer completes on ack.
- ack while in IDLE is ignored.
- A bit that becomes masked after it is presented is still cleared on ack.
- Latency:
  - req bit sampled high (edge) at clock edge E0 -> pending bit visible after E0 -> valid=1 after E1. Two cycles from req to valid.
  - ack at edge Ea -> valid=0 after Ea. Next valid at the earliest after Ea+1, so there is always at least one IDLE cycle between grants.
  - Back-to-back service of 8 pending bits takes 16 cycles with ack held high.
- Priority is fixed: bit 7 over bit 0. No fairness; starvation of low bits under sustained high-bit traffic is accepted.
- A mid-operation reset (valid=1, pending!=0) drops valid and pending on that edge. Requests seen during reset are lost.

Test Plan:
1. Reset then single request: rst=1 for 2 cycles, en=1, mask=0, EDGE=1, req=8'b00000100 held -> pending=8'h04 one cycle after edge, valid=1 with y=3'd2 one cycle later. ack=1 for one cycle -> valid=0, pending=8'h00, overflow never asserted.
2. Priority and drain: pending loaded with req=8'b10100001 pulsed one cycle, ack held 1 -> y sequence 7,5,0. valid high 1 cycle, low 1 cycle between grants. pending ends 8'h00 after 6 cycles of service.
3. Masking and en gating:
   - mask=8'h80, req pulse 8'h81 -> y=0 presented first, pending retains 8'h80 after ack.
   - en=0 with pending!=0 -> valid stays 0. Raising en -> valid next cycle.
4. Hold stability: valid=1, y=3'd6, ack=0 for 5 cycles while a new req bit 7 pulses and mask changes to 8'h40 -> y stays 6 and valid stays 1 for all 5 cycles. After ack, next grant is y=7.
5. Simultaneous set/clear and overflow: while y=3 presented, pulse req[3] in the same cycle as ack -> pending[3] remains 1 and overflow=0. Re-pulse req[3] while pending[3]=1 with no ack -> overflow=1 for exactly one cycle.
6. Level mode and mid-operation reset: EDGE=0, req=8'h02 held -> bit 1 re-presented after every ack (y=1, 1 cycle on / 1 cycle off). Assert rst while valid=1 -> valid=0, pending=8'h00, y=0 next cycle.
